// File: rtl/ann_seq_if.sv
// ann_seq_if: control/data bundle between the ANN sequencer and its datapath/ROM.
//   master : sequencer side (drives strobes, ROM address, data_out; reads start, mem_rdata)
//   slave  : datapath/ROM side (opposite directions)
interface ann_seq_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic [15:0] data_out;
  logic        ld_in, ld_weight, ld_bias_LSB, ld_bias_MSB;
  logic        shift_in, change, ld_multiplication, rst_sum;
  logic        bias_addition, ReLU_computation, ld_max_func;
  logic [3:0]  ld_neuron;

  modport master (
    input  start, mem_rdata,
    output busy, done, mem_addr, mem_rd_en, data_out,
           ld_in, ld_weight, ld_bias_LSB, ld_bias_MSB,
           shift_in, change, ld_multiplication, rst_sum,
           bias_addition, ReLU_computation, ld_max_func, ld_neuron
  );

  modport slave (
    output start, mem_rdata,
    input  busy, done, mem_addr, mem_rd_en, data_out,
           ld_in, ld_weight, ld_bias_LSB, ld_bias_MSB,
           shift_in, change, ld_multiplication, rst_sum,
           bias_addition, ReLU_computation, ld_max_func, ld_neuron
  );
endinterface

// File: rtl/ann_sequencer.sv
// ann_sequencer: steps a fully-connected layer through input load, per-neuron
// weight MAC, bias load/add and ReLU, then a final max stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ann_seq_if.master -- start/busy/done, ROM read port, datapath strobes
// Outputs are decoded from the current state and counters and then registered,
// so every output lags the state register by one cycle; data_out is the only
// combinational output (ROM data gated by the registered load strobes).
module ann_sequencer #(
  parameter int N_IN     = 32,
  parameter int N_NEURON = 10,
  parameter int W_BASE   = 32,
  parameter int B_BASE   = 352
) (
  input  logic clk,
  input  logic rst,
  ann_seq_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLR, MAC, DRAIN, BIAS, BADD, RELU, MAX, DONE
  } state_t;

  typedef struct packed {
    logic       busy, done, mem_rd_en;
    logic [8:0] mem_addr;
    logic       ld_in, ld_weight, ld_bias_lsb, ld_bias_msb;
    logic       shift_in, change, ld_mult, rst_sum, bias_add, relu, ld_max;
    logic [3:0] ld_neuron;
  } ctl_t;

  localparam int              KW     = (N_IN < 3) ? 2 : $clog2(N_IN + 1);
  localparam logic [KW-1:0]   K_LAST = KW'(N_IN);
  localparam logic [3:0]      N_LAST = 4'(N_NEURON - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    n_q, n_d;
  ctl_t          ctl_q, ctl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      ctl_q   <= ctl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q + KW'(1);
    n_d     = n_q;
    ctl_d   = '0;
    ctl_d.busy = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        k_d = '0;
        n_d = '0;
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        // read in cycles 0..N_IN-1, strobe the returned word one cycle later
        if (k_q != K_LAST) begin
          ctl_d.mem_rd_en = 1'b1;
          ctl_d.mem_addr  = 9'(k_q);
        end
        ctl_d.ld_in = (k_q != '0);
        if (k_q == K_LAST) begin
          state_d = CLR;
          k_d     = '0;
          n_d     = '0;
        end
      end
      CLR: begin
        ctl_d.rst_sum   = 1'b1;
        ctl_d.ld_neuron = n_q;
        state_d         = MAC;
        k_d             = '0;
      end
      MAC: begin
        ctl_d.ld_neuron = n_q;
        if (k_q != K_LAST) begin
          ctl_d.mem_rd_en = 1'b1;
          ctl_d.mem_addr  = 9'(W_BASE + 32'(n_q) * N_IN + 32'(k_q));
        end
        ctl_d.ld_weight = (k_q != '0);
        ctl_d.shift_in  = (k_q != '0);
        ctl_d.ld_mult   = (k_q == KW'(1));
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
        end
      end
      DRAIN: begin
        ctl_d.ld_neuron = n_q;
        if (k_q == KW'(1)) begin
          state_d = BIAS;
          k_d     = '0;
        end
      end
      BIAS: begin
        ctl_d.ld_neuron = n_q;
        if (k_q == KW'(0) || k_q == KW'(1)) begin
          ctl_d.mem_rd_en = 1'b1;
          ctl_d.mem_addr  = 9'(B_BASE + 2 * 32'(n_q) + 32'(k_q));
        end
        ctl_d.ld_bias_lsb = (k_q == KW'(1));
        ctl_d.ld_bias_msb = (k_q == KW'(2));
        if (k_q == KW'(2)) begin
          state_d = BADD;
          k_d     = '0;
        end
      end
      BADD: begin
        ctl_d.ld_neuron = n_q;
        ctl_d.bias_add  = 1'b1;
        state_d         = RELU;
        k_d             = '0;
      end
      RELU: begin
        ctl_d.ld_neuron = n_q;
        ctl_d.relu      = 1'b1;
        k_d             = '0;
        if (n_q == N_LAST) begin
          state_d = MAX;
        end else begin
          n_d     = n_q + 4'd1;
          state_d = CLR;
        end
      end
      MAX: begin
        ctl_d.ld_max = 1'b1;
        state_d      = DONE;
        k_d          = '0;
      end
      DONE: begin
        ctl_d.done = 1'b1;
        state_d    = IDLE;
        k_d        = '0;
        n_d        = '0;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
        n_d     = '0;
      end
    endcase

    // change flips together with each weight strobe
    ctl_d.change = ctl_q.change ^ ctl_d.ld_weight;
  end

  assign bus.busy              = ctl_q.busy;
  assign bus.done              = ctl_q.done;
  assign bus.mem_rd_en         = ctl_q.mem_rd_en;
  assign bus.mem_addr          = ctl_q.mem_addr;
  assign bus.ld_in             = ctl_q.ld_in;
  assign bus.ld_weight         = ctl_q.ld_weight;
  assign bus.ld_bias_LSB       = ctl_q.ld_bias_lsb;
  assign bus.ld_bias_MSB       = ctl_q.ld_bias_msb;
  assign bus.shift_in          = ctl_q.shift_in;
  assign bus.change            = ctl_q.change;
  assign bus.ld_multiplication = ctl_q.ld_mult;
  assign bus.rst_sum           = ctl_q.rst_sum;
  assign bus.bias_addition     = ctl_q.bias_add;
  assign bus.ReLU_computation  = ctl_q.relu;
  assign bus.ld_max_func       = ctl_q.ld_max;
  assign bus.ld_neuron         = ctl_q.ld_neuron;

  // ROM word arrives the cycle after the read, exactly when its strobe is up
  assign bus.data_out = (ctl_q.ld_in | ctl_q.ld_weight | ctl_q.ld_bias_lsb | ctl_q.ld_bias_msb)
                      ? bus.mem_rdata : 16'h0000;

endmodule
